// File: rtl/pipelined_calculator_engine.sv
// rtl/pipelined_calculator_engine.sv - self-sequenced 3-stage calculator (fetch/decode/execute) with result handshake
// Optional CALC_FLAGS_EN adds registered Zero/Sign outputs alongside Result.
module pipelined_calculator_engine #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int OPERAND_WIDTH = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           Start,
  input  logic [ADDRESS_WIDTH:0]         Program_Length,
  output logic                           Busy,
  output logic                           Done,
  output logic [ADDRESS_WIDTH-1:0]       Imem_Address,
  input  logic [2*OPERAND_WIDTH+1:0]     Imem_Data,
  output logic [2*OPERAND_WIDTH+1:0]     Result,
  output logic                           Result_Valid,
  input  logic                           Result_Ready
`ifdef CALC_FLAGS_EN
  ,
  output logic                           Zero,
  output logic                           Sign
`endif
);
  localparam int OW = OPERAND_WIDTH;
  localparam int DW = 2 * OPERAND_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] r_last_addr;
  logic                     r_busy;
  logic                     r_done;
  logic [DW-1:0]            r_instr_s1;
  logic                     r_valid_s1;
  logic [1:0]               r_operation_s2;
  logic [OW-1:0]            r_operand_1_s2;
  logic [OW-1:0]            r_operand_2_s2;
  logic                     r_valid_s2;
  logic [DW-1:0]            r_result;
  logic                     r_result_valid;
`ifdef CALC_FLAGS_EN
  logic                     r_zero;
  logic                     r_sign;
`endif

  logic                     w_stall;
  logic                     w_fetch;
  logic [OW:0]              w_sum;
  logic [OW:0]              w_diff;
  logic [2*OW-1:0]          w_prod;
  logic [DW-1:0]            w_alu;

  assign w_stall = r_result_valid && !Result_Ready;
  assign w_fetch = (r_state == S_RUN) && !w_stall;

  assign w_sum  = {1'b0, r_operand_1_s2} + {1'b0, r_operand_2_s2};
  assign w_diff = {1'b0, r_operand_1_s2} - {1'b0, r_operand_2_s2};
  assign w_prod = (2*OW)'(r_operand_1_s2) * (2*OW)'(r_operand_2_s2);

  always_comb begin
    w_alu = '0;
    case (r_operation_s2)
      2'b00:   w_alu = {{(DW-OW-1){1'b0}}, w_sum};
      2'b01:   w_alu = {{(DW-OW-1){w_diff[OW]}}, w_diff};
      2'b10:   w_alu = {2'b00, w_prod};
      default: w_alu = {{(DW-OW){1'b0}}, r_operand_1_s2 & r_operand_2_s2};
    endcase
  end

  // Sequencer: the last fetch address is Len-1 in ADDRESS_WIDTH bits, so Len=2^AW ends at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_last_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_pc        <= '0;
            r_last_addr <= Program_Length[ADDRESS_WIDTH-1:0] - {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
            if (Program_Length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_fetch) begin
            r_pc <= r_pc + 1'b1;
            if (r_pc == r_last_addr) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_valid_s1 && !r_valid_s2 && (!r_result_valid || Result_Ready)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every stage advances together; a stalled result freezes the whole pipe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr_s1     <= '0;
      r_valid_s1     <= 1'b0;
      r_operation_s2 <= '0;
      r_operand_1_s2 <= '0;
      r_operand_2_s2 <= '0;
      r_valid_s2     <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
`ifdef CALC_FLAGS_EN
      r_zero         <= 1'b0;
      r_sign         <= 1'b0;
`endif
    end else if (!w_stall) begin
      r_valid_s1 <= w_fetch;
      if (w_fetch) r_instr_s1 <= Imem_Data;
      r_valid_s2 <= r_valid_s1;
      if (r_valid_s1) begin
        r_operation_s2 <= r_instr_s1[DW-1 -: 2];
        r_operand_1_s2 <= r_instr_s1[2*OW-1:OW];
        r_operand_2_s2 <= r_instr_s1[OW-1:0];
      end
      r_result_valid <= r_valid_s2;
      if (r_valid_s2) begin
        r_result <= w_alu;
`ifdef CALC_FLAGS_EN
        r_zero   <= (w_alu == '0);
        r_sign   <= w_alu[DW-1];
`endif
      end
    end
  end

  assign Imem_Address = r_pc;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign Result       = r_result;
  assign Result_Valid = r_result_valid;
`ifdef CALC_FLAGS_EN
  assign Zero         = r_zero;
  assign Sign         = r_sign;
`endif

endmodule

// File: tb/tb_pipelined_calculator_engine.sv
// tb/tb_pipelined_calculator_engine.sv - randomized self-checking bench for pipelined_calculator_engine
module tb_pipelined_calculator_engine;
  logic        CLK;
  logic        RST;
  logic        Start;
  logic [10:0] Program_Length;
  logic        Busy;
  logic        Done;
  logic [9:0]  Imem_Address;
  logic [17:0] Imem_Data;
  logic [17:0] Result;
  logic        Result_Valid;
  logic        Result_Ready;

  logic        b_start;
  logic [2:0]  b_len;
  logic        b_busy;
  logic        b_done;
  logic [1:0]  b_addr;
  logic [17:0] b_data;
  logic [17:0] b_result;
  logic        b_rv;
  logic        b_ready;
`ifdef CALC_FLAGS_EN
  logic        a_zero, a_sign, b_zero, b_sign;
`endif

  logic [17:0] imem   [0:1023];
  logic [17:0] imem_b [0:3];
  logic [17:0] obs_val [$];
  int          obs_cyc [$];
  int          checks;
  int          failures;

  assign Imem_Data = imem[Imem_Address];
  assign b_data    = imem_b[b_addr];

  pipelined_calculator_engine u_dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Program_Length(Program_Length),
    .Busy(Busy), .Done(Done), .Imem_Address(Imem_Address), .Imem_Data(Imem_Data),
    .Result(Result), .Result_Valid(Result_Valid), .Result_Ready(Result_Ready)
`ifdef CALC_FLAGS_EN
    , .Zero(a_zero), .Sign(a_sign)
`endif
  );

  pipelined_calculator_engine #(.ADDRESS_WIDTH(2), .OPERAND_WIDTH(8)) u_dut_small (
    .CLK(CLK), .RST(RST), .Start(b_start), .Program_Length(b_len),
    .Busy(b_busy), .Done(b_done), .Imem_Address(b_addr), .Imem_Data(b_data),
    .Result(b_result), .Result_Valid(b_rv), .Result_Ready(b_ready)
`ifdef CALC_FLAGS_EN
    , .Zero(b_zero), .Sign(b_sign)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [17:0] model(input logic [17:0] ins);
    int a, b;
    a = int'(ins[15:8]);
    b = int'(ins[7:0]);
    case (ins[17:16])
      2'd0:    return 18'(a + b);
      2'd1:    return 18'(a - b);
      2'd2:    return 18'(a * b);
      default: return 18'(a & b);
    endcase
  endfunction

  task automatic load_t1();
    imem[0] = {2'b00, 8'd5, 8'd3};
    imem[1] = {2'b01, 8'd3, 8'd5};
    imem[2] = {2'b10, 8'd255, 8'd255};
    imem[3] = {2'b11, 8'hF0, 8'h3C};
  endtask

  // Cycle 0 is the cycle Start is high; outputs are sampled on the falling edge of each cycle.
  task automatic run_a(input int len, input int pct, input int zlo, input int zhi,
                       input int s2, input int s3, input int max_cyc,
                       output int done_cyc, output int glitch, output int rv_seen);
    logic        rdy, held;
    logic [17:0] hv;
    obs_val.delete();
    obs_cyc.delete();
    done_cyc = -1; glitch = 0; rv_seen = 0; held = 1'b0; hv = '0;
    @(negedge CLK);
    for (int k = 0; k < max_cyc; k++) begin
      if (k > 0) @(negedge CLK);
      Start = (k == 0) || (k == s2) || (k == s3);
      if (Start) Program_Length = (k == 0) ? 11'(len) : 11'(len + 3);
      if (k >= zlo && k <= zhi) rdy = 1'b0;
      else rdy = ($urandom_range(99) < pct);
      Result_Ready = rdy;
      if (held && (!Result_Valid || Result !== hv)) glitch++;
      if (Result_Valid) rv_seen++;
      if (Result_Valid && rdy) begin
        obs_val.push_back(Result);
        obs_cyc.push_back(k);
      end
      held = Result_Valid && !rdy;
      hv = Result;
      if (Done) begin
        done_cyc = k;
        break;
      end
    end
    Start = 1'b0;
    Result_Ready = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b1; Program_Length = 11'd4; b_start = 1'b1; b_len = 3'd4;
    repeat (2) @(negedge CLK);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", Done); end
    checks++; if (Result_Valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%0b exp=0", Result_Valid); end
    checks++; if (Result !== 18'd0) begin failures++; $display("FAIL reset_result got=%0h exp=0", Result); end
    checks++; if (Imem_Address !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", Imem_Address); end
`ifdef CALC_FLAGS_EN
    checks++; if ({a_zero, a_sign} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {a_zero, a_sign}); end
`endif
    RST = 1'b0; Start = 1'b0; b_start = 1'b0;
    @(negedge CLK);
    checks++; if (Busy !== 1'b0 || b_busy !== 1'b0) begin
      failures++; $display("FAIL reset_over_start got=%0b%0b exp=00", Busy, b_busy);
    end
  endtask

  task automatic check_t1_run(input string tag, input int done_cyc, input int extra);
    logic [17:0] exp_v [4];
    exp_v[0] = 18'd8; exp_v[1] = 18'h3FFFE; exp_v[2] = 18'd65025; exp_v[3] = 18'h30;
    checks++; if (obs_val.size() != 4) begin failures++; $display("FAIL %s_count got=%0d exp=4", tag, obs_val.size()); end
    for (int i = 0; i < 4 && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== exp_v[i]) begin failures++; $display("FAIL %s_value[%0d] got=%0h exp=%0h", tag, i, obs_val[i], exp_v[i]); end
    end
    checks++; if (done_cyc != 8 + extra) begin failures++; $display("FAIL %s_done_cycle got=%0d exp=%0d", tag, done_cyc, 8 + extra); end
  endtask

  task automatic test_basic();
    int dc, gl, rv;
    load_t1();
    run_a(4, 100, -1, -1, -1, -1, 50, dc, gl, rv);
    check_t1_run("t1", dc, 0);
    for (int i = 0; i < 4 && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != 4 + i) begin failures++; $display("FAIL t1_cycle[%0d] got=%0d exp=%0d", i, obs_cyc[i], 4 + i); end
    end
    @(negedge CLK);
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++; $display("FAIL t1_after_done got=%0b%0b exp=00", Done, Busy);
    end
  endtask

  task automatic test_stall();
    int dc, gl, rv;
    int exp_c [4];
    exp_c[0] = 4; exp_c[1] = 8; exp_c[2] = 9; exp_c[3] = 10;
    load_t1();
    run_a(4, 100, 5, 7, -1, -1, 50, dc, gl, rv);
    check_t1_run("t2", dc, 3);
    checks++; if (gl != 0) begin failures++; $display("FAIL t2_hold got=%0d exp=0", gl); end
    for (int i = 0; i < 4 && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != exp_c[i]) begin failures++; $display("FAIL t2_cycle[%0d] got=%0d exp=%0d", i, obs_cyc[i], exp_c[i]); end
    end
  endtask

  task automatic test_len_zero();
    int dc, gl, rv;
    run_a(0, 100, -1, -1, -1, -1, 20, dc, gl, rv);
    checks++; if (dc != 1) begin failures++; $display("FAIL t3_done_cycle got=%0d exp=1", dc); end
    checks++; if (rv != 0) begin failures++; $display("FAIL t3_valid_seen got=%0d exp=0", rv); end
  endtask

  task automatic test_mid_reset();
    int dc, gl, rv;
    load_t1();
    @(negedge CLK);
    Program_Length = 11'd4; Start = 1'b1; Result_Ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (k == 5) RST = 1'b1;
    end
    @(negedge CLK);
    checks++; if ({Busy, Done, Result_Valid} !== 3'b000 || Result !== 18'd0 || Imem_Address !== 10'd0) begin
      failures++;
      $display("FAIL t4_reset_outputs got=%0b%0b%0b/%0h/%0h exp=000/0/0", Busy, Done, Result_Valid, Result, Imem_Address);
    end
    RST = 1'b0;
    run_a(4, 100, -1, -1, -1, -1, 50, dc, gl, rv);
    check_t1_run("t4", dc, 0);
  endtask

  task automatic check_model_run(input string tag, input int len, input int dc, input int gl);
    checks++; if (obs_val.size() != len) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, obs_val.size(), len); end
    for (int i = 0; i < len && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== model(imem[i])) begin failures++; $display("FAIL %s_value[%0d] got=%0h exp=%0h", tag, i, obs_val[i], model(imem[i])); end
    end
    checks++; if (gl != 0) begin failures++; $display("FAIL %s_hold got=%0d exp=0", tag, gl); end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (dc != obs_cyc[obs_cyc.size()-1] + 1) begin
        failures++; $display("FAIL %s_done_cycle got=%0d exp=%0d", tag, dc, obs_cyc[obs_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dc, gl, rv;
    for (int i = 0; i < 16; i++) imem[i] = 18'($urandom);
    run_a(6, 100, -1, -1, 2, 3, 60, dc, gl, rv);
    check_model_run("t5", 6, dc, gl);
    checks++; if (dc != 10) begin failures++; $display("FAIL t5_done_cycle got=%0d exp=10", dc); end
  endtask

  task automatic test_random();
    int dc, gl, rv, len;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) imem[i] = 18'($urandom);
      run_a(len, 60, -1, -1, -1, -1, 600, dc, gl, rv);
      check_model_run("rand", len, dc, gl);
    end
  endtask

  task automatic test_full_length();
    int dc, gl, rv;
    for (int i = 0; i < 1024; i++) imem[i] = 18'($urandom);
    run_a(1024, 100, -1, -1, -1, -1, 1100, dc, gl, rv);
    check_model_run("full", 1024, dc, gl);
    checks++; if (dc != 1028) begin failures++; $display("FAIL full_done_cycle got=%0d exp=1028", dc); end
  endtask

  task automatic test_small_aw();
    int nres, dc;
    for (int i = 0; i < 4; i++) imem_b[i] = 18'($urandom);
    nres = 0; dc = -1;
    @(negedge CLK);
    b_len = 3'd4; b_start = 1'b1; b_ready = 1'b1;
    for (int k = 1; k < 40; k++) begin
      @(negedge CLK);
      b_start = 1'b0;
      if (k <= 5) begin
        checks++;
        if (b_addr !== 2'(k - 1)) begin failures++; $display("FAIL t6_addr[%0d] got=%0d exp=%0d", k, b_addr, 2'(k - 1)); end
      end
      if (b_rv) begin
        checks++;
        if (nres >= 4) begin failures++; $display("FAIL t6_extra_result got=%0h exp=none", b_result); end
        else if (b_result !== model(imem_b[nres]) || k != 4 + nres) begin
          failures++; $display("FAIL t6_result[%0d] got=%0h@%0d exp=%0h@%0d", nres, b_result, k, model(imem_b[nres]), 4 + nres);
        end
        nres++;
      end
      if (b_done) begin
        dc = k;
        break;
      end
    end
    checks++; if (nres != 4) begin failures++; $display("FAIL t6_count got=%0d exp=4", nres); end
    checks++; if (dc != 8) begin failures++; $display("FAIL t6_done_cycle got=%0d exp=8", dc); end
  endtask

`ifdef CALC_FLAGS_EN
  task automatic test_flags();
    int dc;
    imem[0] = {2'b01, 8'd3, 8'd5};
    imem[1] = {2'b01, 8'd7, 8'd7};
    dc = -1;
    @(negedge CLK);
    Program_Length = 11'd2; Start = 1'b1; Result_Ready = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (k == 4) begin
        checks++; if ({Result_Valid, a_sign, a_zero} !== 3'b110) begin
          failures++; $display("FAIL t7_sub_neg got=%b exp=110", {Result_Valid, a_sign, a_zero});
        end
      end
      if (k == 5) begin
        checks++; if ({Result_Valid, a_sign, a_zero} !== 3'b101) begin
          failures++; $display("FAIL t7_sub_zero got=%b exp=101", {Result_Valid, a_sign, a_zero});
        end
      end
      if (Done) begin
        dc = k;
        break;
      end
    end
    checks++; if (dc != 6) begin failures++; $display("FAIL t7_done_cycle got=%0d exp=6", dc); end
  endtask
`endif

  initial begin
    CLK = 1'b0; RST = 1'b1; Start = 1'b0; Program_Length = '0; Result_Ready = 1'b1;
    b_start = 1'b0; b_len = '0; b_ready = 1'b1;
    checks = 0; failures = 0;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    for (int i = 0; i < 4; i++) imem_b[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_len_zero();
    test_mid_reset();
    test_start_ignored();
    test_random();
    test_full_length();
    test_small_aw();
`ifdef CALC_FLAGS_EN
    test_flags();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
